smc_in_loader: RTL and testbench

Input-collection and result-capture stage placed directly in front of the SMC code calculator. It receives the six transistors' (W, V_GS, V_DS) triples serially, one per valid beat, with the mode sampled on the first beat. It presents all eighteen fields plus mode to SMC in parallel and holds them stable. It then registers SMC's combinational out_n and returns it with a single-cycle out_valid pulse.

---
 rtl/smc_in_loader.sv | 165 ++++++++++++++++
 tb/tb_smc_in_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/smc_in_loader.sv
// smc_in_loader
//   Collects six (W, V_GS, V_DS) triples, one per accepted beat, and
//   presents them to the SMC calculator in parallel. The mode is taken
//   from beat 0 only. Once the sixth beat lands, the block spends one
//   cycle (EVAL) with the fields stable. It registers SMC's combinational
//   result at the end of that cycle and returns it with a one-cycle
//   out_valid strobe (OUT).
//
//   If the gap between beats inside a frame grows past WAIT_LIMIT idle
//   cycles, the frame is aborted and err pulses for one cycle.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   in_valid                 beat qualifier
//   in_w, in_vgs, in_vds     per-beat fields, 3 bits each
//   in_mode                  frame mode, sampled on beat 0 only
//   in_ready                 beat will be accepted this cycle
//   W_k, V_GS_k, V_DS_k      slot k = beat k, held until overwritten
//   mode                     latched mode
//   smc_out_n                SMC result, combinational from the slot outputs
//   out_valid, out_n         one-cycle result strobe; out_n is 0 otherwise
//   err                      one-cycle pulse on frame abort

// One storage slot holding a {W, V_GS, V_DS} triple.
module smc_in_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [8:0] d,
  output logic [8:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module smc_in_loader #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_w,
  input  logic [2:0] in_vgs,
  input  logic [2:0] in_vds,
  input  logic [1:0] in_mode,
  output logic       in_ready,
  output logic [2:0] W_0,
  output logic [2:0] W_1,
  output logic [2:0] W_2,
  output logic [2:0] W_3,
  output logic [2:0] W_4,
  output logic [2:0] W_5,
  output logic [2:0] V_GS_0,
  output logic [2:0] V_GS_1,
  output logic [2:0] V_GS_2,
  output logic [2:0] V_GS_3,
  output logic [2:0] V_GS_4,
  output logic [2:0] V_GS_5,
  output logic [2:0] V_DS_0,
  output logic [2:0] V_DS_1,
  output logic [2:0] V_DS_2,
  output logic [2:0] V_DS_3,
  output logic [2:0] V_DS_4,
  output logic [2:0] V_DS_5,
  output logic [1:0] mode,
  input  logic [9:0] smc_out_n,
  output logic       out_valid,
  output logic [9:0] out_n,
  output logic       err
);
  localparam int NUM_SLOTS = 6;
  localparam int WW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                 state;
  logic [2:0]                 cnt;
  logic [WW-1:0]              wait_cnt;
  logic [NUM_SLOTS-1:0][8:0]  slot_q;
  logic                       accept;
  logic                       abort;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign accept   = in_valid && in_ready;
  // Abort only on an idle cycle: a beat arriving with the counter already
  // at the limit still wins.
  assign abort    = (state == S_LOAD) && !in_valid && (wait_cnt == WW'(WAIT_LIMIT));

  genvar k;
  generate
    for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
      smc_in_slot u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && (cnt == 3'(k))),
        .d     ({in_w, in_vgs, in_vds}),
        .q     (slot_q[k])
      );
    end
  endgenerate

  assign {W_0, V_GS_0, V_DS_0} = slot_q[0];
  assign {W_1, V_GS_1, V_DS_1} = slot_q[1];
  assign {W_2, V_GS_2, V_DS_2} = slot_q[2];
  assign {W_3, V_GS_3, V_DS_3} = slot_q[3];
  assign {W_4, V_GS_4, V_DS_4} = slot_q[4];
  assign {W_5, V_GS_5, V_DS_5} = slot_q[5];

  // Sequencing: beat counter, idle-gap counter, state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state    <= S_LOAD;
          cnt      <= 3'd1;
          wait_cnt <= '0;
        end
        S_LOAD: begin
          if (in_valid) begin
            wait_cnt <= '0;
            if (cnt == 3'd5) begin
              state <= S_EVAL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end else if (abort) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EVAL:  state <= S_OUT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Mode is taken from beat 0 only, and result and abort strobes are
  // registered so that they line up with the OUT state and the cycle
  // after the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && (state == S_IDLE)) mode <= in_mode;
      out_valid <= (state == S_EVAL);
      out_n     <= (state == S_EVAL) ? smc_out_n : '0;
      err       <= abort;
    end
  end
endmodule

// File: tb/tb_smc_in_loader.sv
module tb_smc_in_loader;
  localparam int WL = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_w = '0, in_vgs = '0, in_vds = '0;
  logic [1:0] in_mode = '0;
  logic       in_ready;
  logic [2:0] W_0, W_1, W_2, W_3, W_4, W_5;
  logic [2:0] V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5;
  logic [2:0] V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5;
  logic [1:0] mode;
  logic [9:0] smc_out_n, out_n;
  logic       out_valid, err;
  logic       use_const = 1'b0;

  always #5 clk = ~clk;

  smc_in_loader #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_w(in_w), .in_vgs(in_vgs), .in_vds(in_vds), .in_mode(in_mode),
    .in_ready(in_ready),
    .W_0(W_0), .W_1(W_1), .W_2(W_2), .W_3(W_3), .W_4(W_4), .W_5(W_5),
    .V_GS_0(V_GS_0), .V_GS_1(V_GS_1), .V_GS_2(V_GS_2),
    .V_GS_3(V_GS_3), .V_GS_4(V_GS_4), .V_GS_5(V_GS_5),
    .V_DS_0(V_DS_0), .V_DS_1(V_DS_1), .V_DS_2(V_DS_2),
    .V_DS_3(V_DS_3), .V_DS_4(V_DS_4), .V_DS_5(V_DS_5),
    .mode(mode), .smc_out_n(smc_out_n),
    .out_valid(out_valid), .out_n(out_n), .err(err)
  );

  logic [2:0] dw [6], dg [6], dd [6];
  assign dw[0] = W_0; assign dw[1] = W_1; assign dw[2] = W_2;
  assign dw[3] = W_3; assign dw[4] = W_4; assign dw[5] = W_5;
  assign dg[0] = V_GS_0; assign dg[1] = V_GS_1; assign dg[2] = V_GS_2;
  assign dg[3] = V_GS_3; assign dg[4] = V_GS_4; assign dg[5] = V_GS_5;
  assign dd[0] = V_DS_0; assign dd[1] = V_DS_1; assign dd[2] = V_DS_2;
  assign dd[3] = V_DS_3; assign dd[4] = V_DS_4; assign dd[5] = V_DS_5;

  // Stand-in SMC: a position-weighted mix of every field and the mode.
  function automatic logic [9:0] smc_fn(input logic [2:0] w [6], input logic [2:0] g [6],
                                        input logic [2:0] d [6], input logic [1:0] m);
    int s;
    s = 37 * int'(m);
    for (int k = 0; k < 6; k++)
      s += (k + 1) * (int'(w[k]) * 8 + int'(g[k])) * 3 + int'(d[k]) * (2 * k + 5);
    return s[9:0];
  endfunction

  always_comb begin
    smc_out_n = '0;
    smc_out_n = use_const ? 10'd345 : smc_fn(dw, dg, dd, mode);
  end

  // Reference model: frame-level view with explicit slot contents.
  logic [2:0] ew [6], eg [6], ed [6];
  logic [1:0] emode;
  int nb, gap, busy, cap;   // busy: 2 = evaluating, 1 = presenting result
  bit perr;
  int checks = 0, errors = 0, nov = 0, nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin ew[k] = '0; eg[k] = '0; ed[k] = '0; end
    emode = '0; nb = 0; gap = 0; busy = 0; cap = 0; perr = 0;
  endtask

  task automatic check_all();
    chk("in_ready", int'(in_ready), int'(busy == 0));
    chk("out_valid", int'(out_valid), int'(busy == 1));
    chk("out_n", int'(out_n), busy == 1 ? cap : 0);
    chk("err", int'(err), int'(perr));
    chk("ov_err_excl", int'(out_valid & err), 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("W_%0d", k), int'(dw[k]), int'(ew[k]));
      chk($sformatf("V_GS_%0d", k), int'(dg[k]), int'(eg[k]));
      chk($sformatf("V_DS_%0d", k), int'(dd[k]), int'(ed[k]));
    end
    chk("mode", int'(mode), int'(emode));
    if (out_valid) nov++;
    if (err) nerr++;
  endtask

  task automatic model_update();
    perr = 0;
    if (busy == 2) begin
      cap  = use_const ? 345 : int'(smc_fn(ew, eg, ed, emode));
      busy = 1;
    end else if (busy == 1) begin
      busy = 0;
    end else if (in_valid) begin
      ew[nb] = in_w; eg[nb] = in_vgs; ed[nb] = in_vds;
      if (nb == 0) emode = in_mode;
      nb++; gap = 0;
      if (nb == 6) begin busy = 2; nb = 0; end
    end else if (nb > 0) begin
      gap++;
      if (gap > WL) begin perr = 1; nb = 0; gap = 0; end
    end
  endtask

  task automatic drive(input bit v, input int w, input int g, input int d, input int m);
    in_valid = v; in_w = 3'(w); in_vgs = 3'(g); in_vds = 3'(d); in_mode = 2'(m);
  endtask

  task automatic step(input bit v, input int w, input int g, input int d, input int m);
    drive(v, w, g, d, m);
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rbeat(input int m);
    step(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), m);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; int w, g, d, m;
    bit rdy, ov; int on;
  } vec_t;
  vec_t tbl [9];

  int ov0, er0, r;

  initial begin
    tbl[0] = '{1, 1, 3, 2, 1, 1, 0, 0};
    tbl[1] = '{1, 2, 4, 4, 0, 1, 0, 0};
    tbl[2] = '{1, 3, 5, 1, 0, 1, 0, 0};
    tbl[3] = '{1, 4, 6, 6, 0, 1, 0, 0};
    tbl[4] = '{1, 5, 7, 3, 0, 1, 0, 0};
    tbl[5] = '{1, 7, 2, 1, 0, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0};   // EVAL
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 345}; // OUT
    tbl[8] = '{0, 0, 0, 0, 0, 1, 0, 0};

    #1;
    do_reset();
    idle(5);

    // Contiguous frame against fixed expectations.
    use_const = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].g, tbl[i].d, tbl[i].m);
      @(negedge clk);
      check_all();
      chk($sformatf("tbl%0d_rdy", i), int'(in_ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_on", i), int'(out_n), tbl[i].on);
      if (i == 6) begin
        chk("eval_W_3", int'(W_3), 4);
        chk("eval_V_GS_5", int'(V_GS_5), 2);
        chk("eval_mode", int'(mode), 1);
      end
      model_update();
      @(posedge clk); #1;
    end
    use_const = 1'b0;

    // Gap of exactly WAIT_LIMIT idles before beat 3 is tolerated.
    ov0 = nov; er0 = nerr;
    rbeat(2); rbeat(1); rbeat(0);
    idle(WL);
    rbeat(3); rbeat(2); rbeat(1);
    idle(3);
    chk("gap_ov_count", nov - ov0, 1);
    chk("gap_err_count", nerr - er0, 0);

    // One idle too many aborts, then a clean frame.
    ov0 = nov; er0 = nerr;
    rbeat(3); rbeat(1); rbeat(2);
    idle(WL + 1);
    idle(2);
    chk("abort_err_count", nerr - er0, 1);
    chk("abort_ov_count", nov - ov0, 0);
    ov0 = nov;
    step(1, 6, 5, 4, 2);
    for (int i = 0; i < 5; i++) rbeat(1);
    idle(3);
    chk("post_abort_ov", nov - ov0, 1);
    chk("post_abort_slot0", int'(W_0), 6);

    // in_valid held high through EVAL/OUT: those beats are dropped.
    for (int i = 0; i < 6; i++) rbeat(i == 0 ? 1 : 0);
    step(1, 7, 7, 7, 3);
    step(1, 7, 7, 7, 3);
    step(1, 2, 3, 4, 2);   // first beat after OUT: new beat 0
    chk("ign_slot0", int'(W_0), 2);
    for (int i = 0; i < 5; i++) rbeat(3);
    idle(3);

    // Reset in the middle of a frame.
    ov0 = nov;
    for (int i = 0; i < 5; i++) rbeat(1);
    do_reset();
    idle(3);
    chk("midrst_ov", nov - ov0, 0);
    for (int i = 0; i < 6; i++) rbeat(i == 0 ? 2 : 1);
    idle(3);
    chk("midrst_frame_ov", nov - ov0, 1);

    // Random traffic with occasional long gaps and resets.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 65) rbeat($urandom_range(0, 3));
      else if (r < 85) idle($urandom_range(1, 3));
      else if (r < 98) idle($urandom_range(WL - 1, WL + 2));
      else do_reset();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
